control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: sequencer for a small bus-based processor datapath.
// A start request in IDLE latches the instruction word into IR. The FSM then
// walks T1..T3 (ALU ops) or only T1 (moves and undefined ops). Every control
// output is decoded from the registered state and IR, never from the live
// inputs, so the datapath sees glitch-free, cycle-aligned enables.
//
// Handshake: run is a one-shot request that is honoured only while busy is
// low (IDLE). There is no ready signal; busy high means run is ignored, and
// done pulses for exactly one cycle in the final step of each instruction.
//
// Port note: "extern" is a reserved word in SystemVerilog, so the
// external-data bus driver enable is named extern_en.
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] instr,
    output logic        busy,
    output logic        done,
    output logic        extern_en,
    output logic        readAddr,
    output logic [2:0]  sel,
    output logic [15:0] ren,
    output logic [15:0] rout,
    output logic        aen,
    output logic        gen,
    output logic        gout,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] ir_q;

    // Decoded IR fields.
    logic [3:0]  op;
    logic [3:0]  rx;
    logic [3:0]  ry;
    logic        is_alu;
    logic [15:0] rx_hot;
    logic [15:0] ry_hot;
    logic        unused_ir_low;

    assign op     = ir_q[15:12];
    assign rx     = ir_q[11:8];
    assign ry     = ir_q[7:4];
    assign is_alu = op[3];
    assign rx_hot = 16'h0001 << rx;
    assign ry_hot = 16'h0001 << ry;

    // The low nibble of the instruction carries no meaning for this machine.
    assign unused_ir_low = ^ir_q[3:0];

    // State is visible for checkers and debug.
    assign state_dbg = state_q;

    // State and IR registers; reset forces IDLE and clears IR immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && run) begin
                ir_q <= instr;
            end
        end
    end

    // Next-state logic: moves and undefined ops finish in T1, ALU ops in T3.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = run ? T1 : IDLE;
            T1:   state_d = is_alu ? T2 : IDLE;
            T2:   state_d = is_alu ? T3 : IDLE;
            T3:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state and IR only; all enables default to zero so
    // IDLE (and therefore reset) drives nothing onto the bus.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        extern_en = 1'b0;
        readAddr  = 1'b0;
        sel       = 3'b000;
        ren       = 16'h0000;
        rout      = 16'h0000;
        aen       = 1'b0;
        gen       = 1'b0;
        gout      = 1'b0;

        busy = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                // Nothing driven while waiting for run.
            end
            T1: begin
                if (is_alu) begin
                    // First operand: Rx onto the bus into A.
                    rout = rx_hot;
                    aen  = 1'b1;
                end else begin
                    case (op[2:0])
                        3'b000: begin
                            // MV: Ry -> Rx over the bus.
                            rout = ry_hot;
                            ren  = rx_hot;
                            done = 1'b1;
                        end
                        3'b001: begin
                            // MVI: external data -> Rx.
                            extern_en = 1'b1;
                            ren       = rx_hot;
                            done      = 1'b1;
                        end
                        3'b010: begin
                            // MVPC: PC address through the external driver -> Rx.
                            extern_en = 1'b1;
                            readAddr  = 1'b1;
                            ren       = rx_hot;
                            done      = 1'b1;
                        end
                        default: begin
                            // Undefined op: complete without touching registers.
                            done = 1'b1;
                        end
                    endcase
                end
            end
            T2: begin
                if (is_alu) begin
                    // Second operand: Ry onto the bus, ALU result into G.
                    rout = ry_hot;
                    gen  = 1'b1;
                    sel  = op[2:0];
                end
            end
            T3: begin
                if (is_alu) begin
                    // Write back: G onto the bus into Rx.
                    gout = 1'b1;
                    ren  = rx_hot;
                    done = 1'b1;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
